pool_rdsch: RTL and testbench

POOL_RDSCH -- requirements
Module: pool_rdsch

---
 rtl/pool_rdsch.sv | 162 ++++++++++++++++
 tb/tb_pool_rdsch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_rdsch.sv
// rtl/pool_rdsch.sv - PEL read scheduler: sweeps PEB psum buffers into a 2-entry
// output FIFO toward pooling, with credit-limited reads.
module pool_rdsch #(
  parameter int NUMPEB     = 16,
  parameter int LENPSUM    = 16,
  parameter int PSUM_WIDTH = 16,
  parameter int DAT_W      = PSUM_WIDTH * LENPSUM,
  localparam int PW        = $clog2(NUMPEB),
  localparam int AW        = $clog2(LENPSUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CTRLPEB_FnhFrm,
  input  logic [PW:0]      CFG_NumPeb,
  input  logic [AW:0]      CFG_NumAddr,
  output logic [PW-1:0]    POOLPEB_EnRd,
  output logic [AW-1:0]    POOLPEB_AddrRd,
  output logic             POOLPEB_ReqRd,
  input  logic [DAT_W-1:0] PELPOOL_Dat,
  output logic             POOL_Val,
  input  logic             POOL_Rdy,
  output logic [DAT_W-1:0] POOL_Dat,
  output logic [PW-1:0]    POOL_Peb,
  output logic [AW-1:0]    POOL_Addr,
  output logic             POOL_Lst,
  output logic             POOLSCH_Busy,
  output logic             POOLSCH_Drop
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             lst;
    logic [PW-1:0]    peb;
    logic [AW-1:0]    addr;
    logic [DAT_W-1:0] dat;
  } word_t;

  state_t        state;
  logic [PW:0]   numPebQ;
  logic [AW:0]   numAddrQ;
  logic [PW-1:0] pebCnt, lastPeb, pendPeb;
  logic [AW-1:0] addrCnt, lastAddrRd, pendAddr;
  logic          pendVal, pendLst;
  logic [1:0]    occ;
  word_t         head, tail, pushWord;
  logic [2:0]    outstanding;
  logic          popW, issue, lastAddr, lastPeb1;

  // Credit counts the slot freed by this cycle's pop, so Rdy held high sustains one read per cycle.
  assign popW        = POOL_Val && POOL_Rdy;
  assign outstanding = {1'b0, occ} + {2'b0, pendVal} - {2'b0, popW};
  assign issue       = (state == READ) && (outstanding < 3'd2);
  assign lastAddr    = ({1'b0, addrCnt} == numAddrQ - 1'b1);
  assign lastPeb1    = ({1'b0, pebCnt} == numPebQ - 1'b1);

  assign POOLPEB_ReqRd  = issue;
  assign POOLPEB_EnRd   = issue ? pebCnt : lastPeb;
  assign POOLPEB_AddrRd = issue ? addrCnt : lastAddrRd;

  assign POOL_Val  = (occ != 2'd0);
  assign POOL_Dat  = head.dat;
  assign POOL_Peb  = head.peb;
  assign POOL_Addr = head.addr;
  assign POOL_Lst  = head.lst;
  assign pushWord  = {pendLst, pendPeb, pendAddr, PELPOOL_Dat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      numPebQ      <= '0;
      numAddrQ     <= '0;
      pebCnt       <= '0;
      addrCnt      <= '0;
      lastPeb      <= '0;
      lastAddrRd   <= '0;
      POOLSCH_Busy <= 1'b0;
      POOLSCH_Drop <= 1'b0;
    end else begin
      POOLSCH_Drop <= CTRLPEB_FnhFrm && (state != IDLE);
      case (state)
        IDLE: begin
          if (CTRLPEB_FnhFrm) begin
            if ((CFG_NumPeb != '0) && (CFG_NumAddr != '0)) begin
              numPebQ      <= CFG_NumPeb;
              numAddrQ     <= CFG_NumAddr;
              pebCnt       <= '0;
              addrCnt      <= '0;
              POOLSCH_Busy <= 1'b1;
              state        <= READ;
            end else begin
              state <= DONE;
            end
          end
        end
        READ: begin
          if (issue) begin
            lastPeb    <= pebCnt;
            lastAddrRd <= addrCnt;
            if (lastAddr) begin
              addrCnt <= '0;
              if (lastPeb1) state  <= DRAIN;
              else          pebCnt <= pebCnt + 1'b1;
            end else begin
              addrCnt <= addrCnt + 1'b1;
            end
          end
        end
        DRAIN: if (popW && POOL_Lst) state <= DONE;
        default: begin
          POOLSCH_Busy <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Tags ride alongside the read so they line up with the data returning next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendVal  <= 1'b0;
      pendLst  <= 1'b0;
      pendPeb  <= '0;
      pendAddr <= '0;
    end else begin
      pendVal  <= issue;
      pendLst  <= issue && lastAddr && lastPeb1;
      pendPeb  <= pebCnt;
      pendAddr <= addrCnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({pendVal, popW})
        2'b10: begin
          if (occ == 2'd0) head <= pushWord;
          else             tail <= pushWord;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= pushWord;
          end else begin
            head <= tail;
            tail <= pushWord;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_rdsch.sv
// tb/tb_pool_rdsch.sv - directed scoreboard bench for pool_rdsch
module tb_pool_rdsch;
  localparam int NUMPEB = 16, LENPSUM = 16, PSUM_WIDTH = 16;
  localparam int DAT_W = PSUM_WIDTH * LENPSUM;
  localparam int PW = 4, AW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             fnh;
  logic [PW:0]      cfgNumPeb;
  logic [AW:0]      cfgNumAddr;
  logic [PW-1:0]    enRd;
  logic [AW-1:0]    addrRd;
  logic             reqRd;
  logic [DAT_W-1:0] pelDat;
  logic             val, rdy, lst, busy, drop;
  logic [DAT_W-1:0] dat;
  logic [PW-1:0]    peb;
  logic [AW-1:0]    addr;

  pool_rdsch #(.NUMPEB(NUMPEB), .LENPSUM(LENPSUM), .PSUM_WIDTH(PSUM_WIDTH)) dut (
    .clk(clk), .rst(rst), .CTRLPEB_FnhFrm(fnh), .CFG_NumPeb(cfgNumPeb),
    .CFG_NumAddr(cfgNumAddr), .POOLPEB_EnRd(enRd), .POOLPEB_AddrRd(addrRd),
    .POOLPEB_ReqRd(reqRd), .PELPOOL_Dat(pelDat), .POOL_Val(val), .POOL_Rdy(rdy),
    .POOL_Dat(dat), .POOL_Peb(peb), .POOL_Addr(addr), .POOL_Lst(lst),
    .POOLSCH_Busy(busy), .POOLSCH_Drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               peb;
    int               addr;
    bit               lst;
    logic [DAT_W-1:0] dat;
  } exp_t;

  exp_t q[$];
  int   nCmp = 0, nErr = 0;
  int   salt = 0, cyc = 0;
  int   issued = 0, popped = 0, dropCnt = 0, valSeen = 0;
  int   firstPop = -1, lastPop = -1;
  bit   pelReq = 0;
  int   pelPeb = 0, pelAddr = 0;
  bit   stallPrev = 0;
  logic [DAT_W-1:0] sDat;
  logic [PW-1:0]    sPeb;
  logic [AW-1:0]    sAddr;
  logic             sLst;

  function automatic logic [DAT_W-1:0] mkDat(int p, int a, int s);
    logic [31:0] w;
    w = {s[7:0], 8'hC3, p[7:0], a[7:0]};
    return {8{w}};
  endfunction

  task automatic chk(string tag, logic [DAT_W-1:0] obs, logic [DAT_W-1:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // PEL model: answers a read one cycle after the strobe; idle cycles carry junk.
  always begin
    @(posedge clk);
    #1;
    pelDat = pelReq ? mkDat(pelPeb, pelAddr, salt) : {8{$urandom}};
  end

  always @(negedge clk) begin
    if (rst) begin
      pelReq    = 0;
      stallPrev = 0;
    end else begin
      if (stallPrev) begin
        chk("stall val", val, 1'b1);
        chk("stall dat", dat, sDat);
        chk("stall peb", peb, sPeb);
        chk("stall addr", addr, sAddr);
        chk("stall lst", lst, sLst);
      end
      if (val && rdy) begin
        popped++;
        if (firstPop < 0) firstPop = cyc;
        lastPop = cyc;
        chk("unexpected pop", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("pop peb", peb, e.peb);
          chk("pop addr", addr, e.addr);
          chk("pop lst", lst, e.lst);
          chk("pop dat", dat, e.dat);
        end
      end
      if (reqRd) begin
        issued++;
        chk("outstanding<=2", (issued - popped) <= 2, 1'b1);
      end
      stallPrev = val && !rdy;
      sDat = dat; sPeb = peb; sAddr = addr; sLst = lst;
      if (drop) dropCnt++;
      if (val) valSeen++;
      pelReq  = reqRd;
      pelPeb  = int'(enRd);
      pelAddr = int'(addrRd);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(int np, int na);
    fnh        = 1'b1;
    cfgNumPeb  = np[PW:0];
    cfgNumAddr = na[AW:0];
    if (np > 0 && na > 0)
      for (int p = 0; p < np; p++)
        for (int a = 0; a < na; a++)
          q.push_back('{p, a, (p == np - 1) && (a == na - 1), mkDat(p, a, salt)});
    tick(1);
    fnh = 1'b0;
  endtask

  task automatic drain(string tag, int budget);
    int n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, " drained"}, q.size(), 0);
    chk({tag, " busy low"}, busy, 1'b0);
  endtask

  task automatic resetCounts();
    issued = 0; popped = 0; dropCnt = 0; valSeen = 0;
    firstPop = -1; lastPop = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fnh = 1'b0; cfgNumPeb = '0; cfgNumAddr = '0; rdy = 1'b0; pelDat = '0;
    tick(2);
    chk("rst val", val, 1'b0);
    chk("rst reqrd", reqRd, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst drop", drop, 1'b0);
    chk("rst enrd", enRd, 0);
    chk("rst addrrd", addrRd, 0);
    chk("rst dat", dat, 0);
    chk("rst lst", lst, 1'b0);
    rst = 1'b0;
    tick(2);

    // 2x3 sweep, Rdy high: timing of first word and back-to-back output
    salt = 1; rdy = 1'b1; resetCounts();
    start(2, 3);
    chk("t1 busy", busy, 1'b1);
    chk("t1 val c0", val, 1'b0);
    tick(1);
    chk("t1 val c1", val, 1'b0);
    tick(1);
    chk("t1 val c2", val, 1'b1);
    drain("t1", 40);
    chk("t1 words", popped, 6);
    chk("t1 back-to-back", lastPop - firstPop, 5);

    // 1x4 sweep, Rdy toggling
    salt = 2; resetCounts();
    start(1, 4);
    for (int n = 0; n < 60 && q.size() != 0; n++) begin
      tick(1);
      rdy = ~rdy;
    end
    rdy = 1'b1;
    drain("t2", 20);
    chk("t2 words", popped, 4);

    // Rdy low for 10 cycles: only two reads may go out
    salt = 3; rdy = 1'b0; resetCounts();
    start(2, 3);
    tick(9);
    chk("t3 reads stalled", issued, 2);
    chk("t3 val", val, 1'b1);
    rdy = 1'b1;
    drain("t3", 40);
    chk("t3 reads total", issued, 6);

    // second start during READ is dropped
    salt = 4; resetCounts();
    start(2, 3);
    fnh = 1'b1;
    tick(1);
    fnh = 1'b0;
    chk("t4 drop pulse", drop, 1'b1);
    drain("t4", 40);
    chk("t4 drop count", dropCnt, 1);
    chk("t4 words", popped, 6);

    // zero configuration: DONE for one cycle, no reads, no words
    salt = 5; resetCounts();
    start(0, 3);
    chk("t5 busy", busy, 1'b0);
    start(0, 3);
    tick(1);
    start(3, 0);
    tick(3);
    chk("t5 drop count", dropCnt, 1);
    chk("t5 reads", issued, 0);
    chk("t5 val", valSeen, 0);
    chk("t5 busy end", busy, 1'b0);

    // boundary shapes
    salt = 6; resetCounts();
    start(3, 1);
    drain("t6a", 40);
    start(1, 1);
    drain("t6b", 20);
    start(16, 16);
    drain("t6c", 600);
    chk("t6 words", popped, 3 + 1 + 256);

    // reset mid-READ with FIFO full
    salt = 7; rdy = 1'b0; resetCounts();
    start(2, 3);
    tick(5);
    chk("t7 full val", val, 1'b1);
    rst = 1'b1;
    #1;
    chk("t7 rst val", val, 1'b0);
    chk("t7 rst reqrd", reqRd, 1'b0);
    chk("t7 rst busy", busy, 1'b0);
    chk("t7 rst dat", dat, 0);
    q.delete();
    tick(2);
    rst = 1'b0;
    salt = 8; rdy = 1'b1; resetCounts();
    tick(1);
    start(1, 2);
    drain("t7", 20);
    chk("t7 words", popped, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
